// File: rtl/vx_mul_sign_pipe.sv
// Signed/unsigned N x N multiply pipeline (RISC-V MUL/MULH/MULHSU/MULHU) around an unsigned core.
// Optional perf counters perf_ops/perf_stalls are built when VX_MUL_PERF_EN is defined.
module vx_mul_sign_pipe #(
  parameter int N       = 32,
  parameter int TAG_W   = 8,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_a_signed,
  input  logic             in_b_signed,
  input  logic             in_hi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef VX_MUL_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stalls
`endif
);

  // Delay stages between the product register and the output register; MID may be 0.
  localparam int MID  = LATENCY - 2;
  localparam int MSZ  = (MID > 0) ? MID : 1;
  localparam int TAIL = (MID > 0) ? MID - 1 : 0;
  localparam int P    = 2 * N;

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic neg);
    magnitude = neg ? (~v + N'(1)) : v;
  endfunction

  function automatic logic [P-1:0] apply_sign(input logic [P-1:0] v, input logic neg);
    apply_sign = neg ? (~v + P'(1)) : v;
  endfunction

  logic stall_s;
  logic adv_s;

  logic             s0_valid_q, s0_valid_d;
  logic [N-1:0]     s0_amag_q, s0_amag_d;
  logic [N-1:0]     s0_bmag_q, s0_bmag_d;
  logic             s0_neg_q, s0_neg_d;
  logic             s0_hi_q, s0_hi_d;
  logic [TAG_W-1:0] s0_tag_q, s0_tag_d;

  logic [P-1:0]     core_prod_s;

  logic             mid_valid_q [MSZ];
  logic             mid_valid_d [MSZ];
  logic [P-1:0]     mid_prod_q  [MSZ];
  logic [P-1:0]     mid_prod_d  [MSZ];
  logic             mid_neg_q   [MSZ];
  logic             mid_neg_d   [MSZ];
  logic             mid_hi_q    [MSZ];
  logic             mid_hi_d    [MSZ];
  logic [TAG_W-1:0] mid_tag_q   [MSZ];
  logic [TAG_W-1:0] mid_tag_d   [MSZ];

  logic             tail_valid_s;
  logic [P-1:0]     tail_prod_s;
  logic             tail_neg_s;
  logic             tail_hi_s;
  logic [TAG_W-1:0] tail_tag_s;
  logic [P-1:0]     res_s;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // Global enable: a held output freezes every stage.
  always_comb begin
    stall_s  = out_valid_q & ~out_ready;
    adv_s    = ~stall_s;
    in_ready = adv_s;
  end

  // Stage 0: sign detection and magnitude capture, sampled only on accept.
  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_amag_d  = s0_amag_q;
    s0_bmag_d  = s0_bmag_q;
    s0_neg_d   = s0_neg_q;
    s0_hi_d    = s0_hi_q;
    s0_tag_d   = s0_tag_q;
    if (adv_s) begin
      s0_valid_d = in_valid;
      if (in_valid) begin
        s0_amag_d = magnitude(in_a, in_a_signed & in_a[N-1]);
        s0_bmag_d = magnitude(in_b, in_b_signed & in_b[N-1]);
        s0_neg_d  = (in_a_signed & in_a[N-1]) ^ (in_b_signed & in_b[N-1]);
        s0_hi_d   = in_hi;
        s0_tag_d  = in_tag;
      end else begin
        s0_amag_d = s0_amag_q;
      end
    end else begin
      s0_valid_d = s0_valid_q;
    end
  end

  // Stage 0 register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_valid_q <= 1'b0;
      s0_amag_q  <= '0;
      s0_bmag_q  <= '0;
      s0_neg_q   <= 1'b0;
      s0_hi_q    <= 1'b0;
      s0_tag_q   <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_amag_q  <= s0_amag_d;
      s0_bmag_q  <= s0_bmag_d;
      s0_neg_q   <= s0_neg_d;
      s0_hi_q    <= s0_hi_d;
      s0_tag_q   <= s0_tag_d;
    end
  end

  // Unsigned core multiplier on the magnitudes.
  always_comb begin
    core_prod_s = P'(s0_amag_q) * P'(s0_bmag_q);
  end

  // Delay chain: slot 0 takes the core product, later slots shift.
  always_comb begin
    for (int i = 0; i < MSZ; i++) begin
      mid_valid_d[i] = mid_valid_q[i];
      mid_prod_d[i]  = mid_prod_q[i];
      mid_neg_d[i]   = mid_neg_q[i];
      mid_hi_d[i]    = mid_hi_q[i];
      mid_tag_d[i]   = mid_tag_q[i];
    end
    if (adv_s) begin
      mid_valid_d[0] = s0_valid_q;
      mid_prod_d[0]  = core_prod_s;
      mid_neg_d[0]   = s0_neg_q;
      mid_hi_d[0]    = s0_hi_q;
      mid_tag_d[0]   = s0_tag_q;
      for (int i = 1; i < MSZ; i++) begin
        mid_valid_d[i] = mid_valid_q[i-1];
        mid_prod_d[i]  = mid_prod_q[i-1];
        mid_neg_d[i]   = mid_neg_q[i-1];
        mid_hi_d[i]    = mid_hi_q[i-1];
        mid_tag_d[i]   = mid_tag_q[i-1];
      end
    end else begin
      mid_valid_d[0] = mid_valid_q[0];
    end
  end

  // Delay chain registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MSZ; i++) begin
        mid_valid_q[i] <= 1'b0;
        mid_prod_q[i]  <= '0;
        mid_neg_q[i]   <= 1'b0;
        mid_hi_q[i]    <= 1'b0;
        mid_tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MSZ; i++) begin
        mid_valid_q[i] <= mid_valid_d[i];
        mid_prod_q[i]  <= mid_prod_d[i];
        mid_neg_q[i]   <= mid_neg_d[i];
        mid_hi_q[i]    <= mid_hi_d[i];
        mid_tag_q[i]   <= mid_tag_d[i];
      end
    end
  end

  // With LATENCY=2 the output stage reads the core product directly.
  always_comb begin
    if (MID > 0) begin
      tail_valid_s = mid_valid_q[TAIL];
      tail_prod_s  = mid_prod_q[TAIL];
      tail_neg_s   = mid_neg_q[TAIL];
      tail_hi_s    = mid_hi_q[TAIL];
      tail_tag_s   = mid_tag_q[TAIL];
    end else begin
      tail_valid_s = s0_valid_q;
      tail_prod_s  = core_prod_s;
      tail_neg_s   = s0_neg_q;
      tail_hi_s    = s0_hi_q;
      tail_tag_s   = s0_tag_q;
    end
    res_s = apply_sign(tail_prod_s, tail_neg_s);
  end

  // Output stage: sign re-application and half select; data held across bubbles and stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (adv_s) begin
      out_valid_d = tail_valid_s;
      if (tail_valid_s) begin
        out_data_d = tail_hi_s ? res_s[P-1:N] : res_s[N-1:0];
        out_tag_d  = tail_tag_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef VX_MUL_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_ops_d    = perf_ops_q + ((out_valid_q & out_ready) ? 32'd1 : 32'd0);
    perf_stalls_d = perf_stalls_q + (stall_s ? 32'd1 : 32'd0);
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ops_q    <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      perf_ops_q    <= perf_ops_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_ops    = perf_ops_q;
  assign perf_stalls = perf_stalls_q;
`else
`endif

endmodule

// File: tb/tb_vx_mul_sign_pipe.sv
// Scoreboard bench for vx_mul_sign_pipe: directed corner cases, back-to-back, stall, reset, random.
module tb_vx_mul_sign_pipe;
  localparam int N   = 32;
  localparam int TW  = 8;
  localparam int LAT = 3;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid, in_ready;
  logic [N-1:0]  in_a, in_b;
  logic          in_a_signed, in_b_signed, in_hi;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef VX_MUL_PERF_EN
  logic [31:0]   perf_ops, perf_stalls;
`endif

  vx_mul_sign_pipe #(.N(N), .TAG_W(TW), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_a_signed(in_a_signed), .in_b_signed(in_b_signed), .in_hi(in_hi),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef VX_MUL_PERF_EN
    , .perf_ops(perf_ops), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   out_cyc_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b1;
  bit   rec_out = 1'b0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: full-precision signed/unsigned product in 64-bit arithmetic, then half select.
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic as, input logic bs, input logic hi);
    longint ea, eb, p;
    logic [63:0] pv;
    ea = as ? longint'($signed(a)) : longint'({32'h0, a});
    eb = bs ? longint'($signed(b)) : longint'({32'h0, b});
    p  = ea * eb;
    pv = p;
    return hi ? pv[63:32] : pv[31:0];
  endfunction

  // Monitor: every output handshake is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (rec_out) out_cyc_q.push_back(cyc);
      if (sbq.size() == 0) begin
        check("unexpected_output", {56'h0, out_tag}, 64'hdead);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_data", {32'h0, out_data}, {32'h0, e.data});
        check("out_tag", {56'h0, out_tag}, {56'h0, e.tag});
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LAT));
      end
    end
  end

  // Random consumer backpressure, active during the random phase only.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one op (entered at posedge+1), push its expectation on accept, leave at posedge+1.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic as,
                       input logic bs, input logic hi, input logic [TW-1:0] tag,
                       input logic [N-1:0] exp);
    int  n;
    bit  acc;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b;
    in_a_signed = as; in_b_signed = bs; in_hi = hi; in_tag = tag;
    n = 0; acc = 1'b0;
    while (!acc && n < TMO) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else n++;
    end
    if (acc) begin
      e.data = exp; e.tag = tag; e.cyc = cyc;
      sbq.push_back(e);
    end else begin
      check("accept_timeout", 64'(n), 64'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 4 * TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sbq.size()), 64'(0));
  endtask

  function automatic logic [N-1:0] rnd_val();
    logic [N-1:0] corner [5];
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'h8000_0000;
    corner[3] = 32'hFFFF_FFFF; corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [N-1:0]  a, b, hold_d;
    logic [TW-1:0] hold_t;
    logic          as, bs, hi;
    logic [31:0]   st0;
    bit            acc;
    int            n;

    resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_a_signed = 1'b0; in_b_signed = 1'b0; in_hi = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_data", {32'h0, out_data}, 64'h0);
    check("rst_out_tag", {56'h0, out_tag}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Architectural corner cases with literal expectations.
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 8'h01, 32'h4000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 8'h02, 32'h0000_0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 8'h03, 32'hFFFF_FFFF);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 8'h04, 32'h0000_0001);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 8'h05, 32'hFFFF_FFFE);
    issue(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 8'h06, 32'hFFFF_FFEB);
    issue(32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b1, 8'h07, 32'h0000_0000);
    issue(32'd5, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 8'h08, 32'hFFFF_FFFD);
    drain();

    // Ten back-to-back ops, tags 0..9, results must be consecutive.
    rec_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; as = 1'($urandom); bs = 1'($urandom); hi = 1'($urandom);
      issue(a, b, as, bs, hi, TW'(i), ref_mul(a, b, as, bs, hi));
    end
    drain();
    rec_out = 1'b0;
    check("b2b_count", 64'(out_cyc_q.size()), 64'd10);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check("b2b_consecutive", 64'(out_cyc_q[i] - out_cyc_q[0]), 64'(i));

    // Fill the pipe, then hold out_ready low for 5 cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      issue(a, b, 1'b1, 1'b0, 1'b1, TW'(8'h20 + i), ref_mul(a, b, 1'b1, 1'b0, 1'b1));
    end
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    in_valid = 1'b1; in_a = a; in_b = b; in_a_signed = 1'b1; in_b_signed = 1'b1;
    in_hi = 1'b0; in_tag = 8'h2A; out_ready = 1'b0;
`ifdef VX_MUL_PERF_EN
    st0 = perf_stalls;
`else
    st0 = 32'd0;
`endif
    @(negedge clk);
    hold_d = out_data; hold_t = out_tag;
    check("stall_out_valid", {63'h0, out_valid}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_in_ready", {63'h0, in_ready}, 64'h0);
      check("stall_hold_data", {32'h0, out_data}, {32'h0, hold_d});
      check("stall_hold_tag", {56'h0, out_tag}, {56'h0, hold_t});
    end
    @(posedge clk); #1;
`ifdef VX_MUL_PERF_EN
    check("perf_stalls", 64'(perf_stalls - st0), 64'd5);
`else
    check("stall_base", 64'(st0), 64'd0);
`endif
    out_ready = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < TMO) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else n++;
    end
    check("stall_release_accept", {63'h0, acc}, 64'h1);
    if (acc) begin
      exp_t e;
      e.data = ref_mul(a, b, 1'b1, 1'b1, 1'b0); e.tag = 8'h2A; e.cyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset with two ops in flight: nothing may emerge afterwards.
    in_valid = 1'b1; in_a = 32'd3; in_b = 32'd4; in_a_signed = 1'b0; in_b_signed = 1'b0;
    in_hi = 1'b0; in_tag = 8'h55;
    @(posedge clk); #1;
    in_tag = 8'h56;
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("rst_mid_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_mid_out_tag", {56'h0, out_tag}, 64'h0);
    sbq.delete();
    n_out = 0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    repeat (LAT + 6) @(posedge clk);
    #1;
    check("rst_no_stale", {63'h0, out_valid}, 64'h0);

    // Random phase: random modes, operands, gaps and backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      a = rnd_val(); b = rnd_val();
      as = 1'($urandom); bs = 1'($urandom); hi = 1'($urandom);
      issue(a, b, as, bs, hi, TW'(i), ref_mul(a, b, as, bs, hi));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;
`ifdef VX_MUL_PERF_EN
    check("perf_ops", {32'h0, perf_ops}, 64'(n_out));
`endif
    check("final_idle", {63'h0, out_valid}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
